// File: rtl/multdiv_issue_if.sv
// Issue-side, multiplier/divider-side and writeback-side signals of the mult/div issue block.
// slave = the issue block, master = the pipeline / md unit / writeback environment.
interface multdiv_issue_if;
    logic        req_valid;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        flush;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_exception;
    logic        wb_timeout;
    logic        wb_ready;
    logic        stall;
    logic [15:0] op_count;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, flush,
               md_result, md_exception, md_resultRDY, wb_ready,
        output req_ready, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
               wb_valid, wb_data, wb_rd, wb_exception, wb_timeout, stall, op_count
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, flush,
               md_result, md_exception, md_resultRDY, wb_ready,
        input  req_ready, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
               wb_valid, wb_data, wb_rd, wb_exception, wb_timeout, stall, op_count
    );
endinterface

// File: rtl/multdiv_issue.sv
// Issues one mult/div operation at a time to an external unit, waits for its result
// (with timeout), and holds the result for writeback.
module multdiv_issue #(
    parameter int MAX_CYCLES = 40
) (
    input  logic          clock,
    input  logic          reset_n,
    multdiv_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam logic [5:0] MAX_CNT = 6'(MAX_CYCLES);

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic        op_q;
    logic [31:0] opa_q, opb_q;
    logic [4:0]  rd_q;
    logic        rdy_int, accept, capture, timeout, retire;
    logic        mult_q, div_q, wb_valid_q, wb_exc_q, wb_to_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic [15:0] op_count_q;

    always_comb begin
        state_nx = state;
        rdy_int  = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        retire   = 1'b0;
        case (state)
            IDLE:    rdy_int = ~bus.flush;
            DONE:    rdy_int = bus.wb_ready & ~bus.flush;
            default: rdy_int = 1'b0;
        endcase
        accept = bus.req_valid & rdy_int;
        case (state)
            IDLE: if (accept) state_nx = START;
            START: state_nx = bus.flush ? IDLE : WAIT;
            WAIT: begin
                // cnt == 0 masks a ready left over from the previous operation
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (cnt != 6'd0 && bus.md_resultRDY) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end else if (cnt == MAX_CNT) begin
                    timeout  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (bus.wb_ready) begin
                    retire   = 1'b1;
                    state_nx = accept ? START : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            rd_q       <= '0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_exc_q   <= 1'b0;
            wb_to_q    <= 1'b0;
            op_count_q <= '0;
        end else begin
            state      <= state_nx;
            mult_q     <= accept & ~bus.req_op;
            div_q      <= accept & bus.req_op;
            wb_valid_q <= (state_nx == DONE);
            if (accept) begin
                op_q  <= bus.req_op;
                opa_q <= bus.req_a;
                opb_q <= bus.req_b;
                rd_q  <= bus.req_rd;
            end
            if (state == START)
                cnt <= '0;
            else if (state == WAIT && cnt != 6'd63)
                cnt <= cnt + 6'd1;
            if (capture) begin
                wb_data_q <= bus.md_result;
                wb_exc_q  <= bus.md_exception;
                wb_to_q   <= 1'b0;
                wb_rd_q   <= rd_q;
            end else if (timeout) begin
                wb_data_q <= '0;
                wb_exc_q  <= 1'b1;
                wb_to_q   <= 1'b1;
                wb_rd_q   <= rd_q;
            end
            if (retire) op_count_q <= op_count_q + 16'd1;
        end
    end

    // Reset overrides the state-derived handshake so the pipeline is never held by a block in reset
    assign bus.req_ready    = ~reset_n | rdy_int;
    assign bus.stall        = reset_n & (state != IDLE) & ~retire;
    assign bus.md_operandA  = opa_q;
    assign bus.md_operandB  = opb_q;
    assign bus.md_ctrl_MULT = mult_q & ~op_q;
    assign bus.md_ctrl_DIV  = div_q & op_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_exception = wb_exc_q;
    assign bus.wb_timeout   = wb_to_q;
    assign bus.op_count     = op_count_q;
endmodule
